// File: rtl/ed_window_sequencer.sv
// Frame-level window sequencer for the error_diffusion stage: buffers two rows,
// issues each pixel's 5-pixel neighbourhood serially, writes results back, streams halftone bits.
module ed_window_sequencer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ed_valid_o,
  output logic [DW-1:0] ed_data_o,
  input  logic          ed_done_i,
  input  logic [DW-1:0] ed_res0_i,
  input  logic [DW-1:0] ed_res1_i,
  input  logic [DW-1:0] ed_res2_i,
  input  logic [DW-1:0] ed_res3_i,
  input  logic [DW-1:0] ed_res4_i,
  output logic          out_valid,
  output logic          out_bit,
  output logic          frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int LW = $clog2(2 * IMG_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [2:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [LW-1:0] ld;
  logic [2:0]    k;
  logic          armed;

  logic [DW-1:0] cur   [IMG_W];
  logic [DW-1:0] nxt   [IMG_W];
  logic [DW-1:0] nxt_w [IMG_W];
  logic [DW-1:0] res0_q, res1_q, res2_q, res3_q, res4_q;

  logic          x_first, x_last, y_last;
  logic [XW-1:0] xp, xm;
  logic [LW-1:0] ld_target;
  logic          xfer, to_cur;
  logic [XW-1:0] ld_idx;
  logic [DW-1:0] issue_data;

  assign x_first = (x == '0);
  assign x_last  = (x == X_LAST);
  assign y_last  = (y == Y_LAST);
  assign xp      = x + 1'b1;
  assign xm      = x - 1'b1;

  // First row loads cur and nxt; the last row has no row below to load.
  assign ld_target = (y == '0) ? LW'(2 * IMG_W) : (y_last ? '0 : LW'(IMG_W));
  assign in_ready  = (state == S_LOAD) && (ld != ld_target);
  assign xfer      = in_ready && in_valid;
  assign to_cur    = (y == '0) && (ld < LW'(IMG_W));
  assign ld_idx    = ((y == '0) && !to_cur) ? XW'(ld - LW'(IMG_W)) : ld[XW-1:0];

  always_comb begin
    issue_data = '0;
    case (k)
      3'd0: issue_data = cur[x];
      3'd1: if (!x_last) issue_data = cur[xp];
      3'd2: if (!x_last && !y_last) issue_data = nxt[xp];
      3'd3: if (!y_last) issue_data = nxt[x];
      3'd4: if (!x_first && !y_last) issue_data = nxt[xm];
      default: issue_data = '0;
    endcase
  end

  assign ed_valid_o = (state == S_ISSUE);
  assign ed_data_o  = ed_valid_o ? issue_data : '0;
  assign out_valid  = (state == S_WB);
  assign out_bit    = out_valid && (res0_q != '0);
  assign frame_done = (state == S_DONE);

  // Lower-row writeback is merged first so a row swap carries this cycle's writes.
  always_comb begin
    nxt_w = nxt;
    if (!y_last) begin
      if (!x_last)  nxt_w[xp] = res2_q;
      nxt_w[x] = res3_q;
      if (!x_first) nxt_w[xm] = res4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      if (to_cur) cur[ld_idx] <= in_data;
      else        nxt[ld_idx] <= in_data;
    end
    if (state == S_WB) begin
      nxt <= nxt_w;
      if (x_last) cur <= nxt_w;
      else        cur[xp] <= res1_q;
    end
    if ((state == S_WAIT) && ed_done_i) begin
      res0_q <= ed_res0_i;
      res1_q <= ed_res1_i;
      res2_q <= ed_res2_i;
      res3_q <= ed_res3_i;
      res4_q <= ed_res4_i;
    end
  end

  // armed blocks a start pulse coinciding with the first edge after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      ld    <= '0;
      k     <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_i && armed) begin
            state <= S_LOAD;
            y     <= '0;
            ld    <= '0;
          end
        end
        S_LOAD: begin
          if (ld == ld_target) begin
            state <= S_ISSUE;
            x     <= '0;
            k     <= '0;
            ld    <= '0;
          end else if (xfer) begin
            ld <= ld + 1'b1;
          end
        end
        S_ISSUE: begin
          if (k == 3'd4) begin
            state <= S_WAIT;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_WAIT: begin
          if (ed_done_i) state <= S_WB;
        end
        S_WB: begin
          if (!x_last) begin
            x     <= x + 1'b1;
            state <= S_ISSUE;
          end else if (!y_last) begin
            y     <= y + 1'b1;
            ld    <= '0;
            state <= S_LOAD;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ed_window_sequencer.sv
// Bench for ed_window_sequencer: two instances (4x2 and 3x4) sharing stimulus,
// an inline error_diffusion stub, and a whole-frame reference image model.
module tb_ed_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b, in_valid, ed_done;
  logic [7:0] in_data, r0, r1, r2, r3, r4;

  logic       a_in_ready, a_ed_valid, a_out_valid, a_out_bit, a_frame_done;
  logic [7:0] a_ed_data;
  logic       b_in_ready, b_ed_valid, b_out_valid, b_out_bit, b_frame_done;
  logic [7:0] b_ed_data;

  logic       sel;
  logic       in_ready, ed_valid, out_valid, out_bit, frame_done;
  logic [7:0] ed_data;

  ed_window_sequencer #(.IMG_W(4), .IMG_H(2), .DW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .ed_valid_o(a_ed_valid), .ed_data_o(a_ed_data), .ed_done_i(ed_done),
    .ed_res0_i(r0), .ed_res1_i(r1), .ed_res2_i(r2), .ed_res3_i(r3), .ed_res4_i(r4),
    .out_valid(a_out_valid), .out_bit(a_out_bit), .frame_done(a_frame_done)
  );

  ed_window_sequencer #(.IMG_W(3), .IMG_H(4), .DW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .ed_valid_o(b_ed_valid), .ed_data_o(b_ed_data), .ed_done_i(ed_done),
    .ed_res0_i(r0), .ed_res1_i(r1), .ed_res2_i(r2), .ed_res3_i(r3), .ed_res4_i(r4),
    .out_valid(b_out_valid), .out_bit(b_out_bit), .frame_done(b_frame_done)
  );

  assign in_ready   = sel ? b_in_ready   : a_in_ready;
  assign ed_valid   = sel ? b_ed_valid   : a_ed_valid;
  assign ed_data    = sel ? b_ed_data    : a_ed_data;
  assign out_valid  = sel ? b_out_valid  : a_out_valid;
  assign out_bit    = sel ? b_out_bit    : a_out_bit;
  assign frame_done = sel ? b_frame_done : a_frame_done;

  int total = 0;
  int bad   = 0;
  int cw, ch;
  logic [7:0] src    [4][4];
  logic [7:0] img    [4][4];
  logic [7:0] issued [4][4][5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_ed_valid"}, ed_valid, 0);
    check({tag, "_ed_data"}, ed_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_bit"}, out_bit, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Neighbourhood of pixel (py,px) in the whole-frame image; outside the frame reads 0.
  function automatic logic [7:0] model_slot(input int py, input int px, input int kk);
    logic [7:0] v;
    v = 8'd0;
    case (kk)
      0: v = img[py][px];
      1: if (px + 1 < cw) v = img[py][px+1];
      2: if (px + 1 < cw && py + 1 < ch) v = img[py+1][px+1];
      3: if (py + 1 < ch) v = img[py+1][px];
      4: if (px > 0 && py + 1 < ch) v = img[py+1][px-1];
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  task automatic send_pixel(input logic [7:0] d, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      ed_done  = 1'b1;
      set_start(1'b1);
      tick();
      ed_done = 1'b0;
      set_start(1'b0);
      check("stall_ready", in_ready, 1);
      check("stall_noissue", ed_valid, 0);
      check("stall_noout", out_valid, 0);
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int gaps, input int rst_px, output int outs);
    int n, nload, row, gap;
    logic [7:0] s [5];
    outs = 0;
    for (int yy = 0; yy < ch; yy++)
      for (int xx = 0; xx < cw; xx++) begin
        src[yy][xx] = (mode < 2) ? 8'(yy * cw + xx) : 8'($urandom_range(0, 255));
        img[yy][xx] = src[yy][xx];
      end
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int yy = 0; yy < ch; yy++) begin
      nload = (yy == 0) ? 2 * cw : ((yy == ch - 1) ? 0 : cw);
      for (int i = 0; i < nload; i++) begin
        row = ((yy == 0) ? 0 : yy + 1) + i / cw;
        gap = (gaps == 1 && yy == 0 && i == 5) ? 3 : ((gaps == 2) ? $urandom_range(0, 2) : 0);
        send_pixel(src[row][i % cw], gap);
      end
      for (int xx = 0; xx < cw; xx++) begin
        n = 0;
        while (!ed_valid && n < 50) begin
          check("preissue_noout", out_valid, 0);
          tick();
          n++;
        end
        if (n == 50) begin
          check("issue_timeout", 0, 1);
          return;
        end
        for (int kk = 0; kk < 5; kk++) begin
          s[kk] = model_slot(yy, xx, kk);
          issued[yy][xx][kk] = ed_data;
          check("issue_valid", ed_valid, 1);
          check("issue_slot", ed_data, s[kk]);
          tick();
        end
        check("wait_novalid", ed_valid, 0);
        if (yy * cw + xx == rst_px) begin
          rst_n = 1'b0;
          tick();
          check_quiet("midreset");
          rst_n = 1'b1;
          tick();
          return;
        end
        tick();
        case (mode)
          0: begin r0 = 8'd0; r1 = s[1]; r2 = s[2]; r3 = s[3]; r4 = s[4]; end
          1: begin r0 = 8'd255; r1 = 8'd200; r2 = 8'd201; r3 = 8'd202; r4 = 8'd203; end
          default: begin
            r0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
          end
        endcase
        ed_done = 1'b1;
        tick();
        ed_done = 1'b0;
        check("wb_valid", out_valid, 1);
        check("wb_bit", out_bit, (r0 != 8'd0));
        outs += int'(out_valid);
        if (xx + 1 < cw) img[yy][xx+1] = r1;
        if (yy + 1 < ch) begin
          if (xx + 1 < cw) img[yy+1][xx+1] = r2;
          img[yy+1][xx] = r3;
          if (xx > 0) img[yy+1][xx-1] = r4;
        end
        tick();
      end
    end
    check("frame_done_pulse", frame_done, 1);
    check("frame_done_noout", out_valid, 0);
    tick();
    check("frame_done_once", frame_done, 0);
    check("idle_after_frame", in_ready, 0);
  endtask

  task automatic spot_issue_order();
    logic [7:0] e00 [5] = '{8'd0, 8'd1, 8'd5, 8'd4, 8'd0};
    logic [7:0] e03 [5] = '{8'd3, 8'd0, 8'd0, 8'd7, 8'd6};
    logic [7:0] e11 [5] = '{8'd5, 8'd6, 8'd0, 8'd0, 8'd0};
    for (int kk = 0; kk < 5; kk++) begin
      check("spot_px00", issued[0][0][kk], e00[kk]);
      check("spot_px03", issued[0][3][kk], e03[kk]);
      check("spot_px11", issued[1][1][kk], e11[kk]);
    end
  endtask

  initial begin
    int outs;
    logic [7:0] e01 [5] = '{8'd200, 8'd2, 8'd6, 8'd201, 8'd202};

    sel = 1'b0; cw = 4; ch = 2;
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    in_valid = 1'b0; in_data = '0; ed_done = 1'b0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0;

    // Reset with start held high, then start coinciding with reset release.
    tick();
    tick();
    check_quiet("reset_a");
    sel = 1'b1;
    check_quiet("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    tick();
    check("start_at_release_a", a_in_ready, 0);
    check("start_at_release_b", b_in_ready, 0);

    // Issue order with echoing stub.
    run_frame(0, 0, -1, outs);
    check("issue_order_outs", outs, 8);
    spot_issue_order();

    // Writeback with constant stub results.
    run_frame(1, 0, -1, outs);
    check("writeback_outs", outs, 8);
    for (int kk = 0; kk < 5; kk++) check("spot_wb_px01", issued[0][1][kk], e01[kk]);

    // Input gap after the fifth pixel.
    run_frame(0, 1, -1, outs);
    check("stall_outs", outs, 8);

    // Reset during WAIT of pixel (0,2), then a clean repeat of the echo frame.
    run_frame(0, 0, 2, outs);
    run_frame(0, 0, -1, outs);
    check("after_reset_outs", outs, 8);
    spot_issue_order();

    for (int f = 0; f < 3; f++) begin
      run_frame(2, 2, -1, outs);
      check("rand_a_outs", outs, 8);
    end

    sel = 1'b1; cw = 3; ch = 4;
    run_frame(0, 0, -1, outs);
    check("b_echo_outs", outs, 12);
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 2, -1, outs);
      check("rand_b_outs", outs, 12);
    end
    check("a_idle_during_b", a_in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ed_window_sequencer.md
# ed_window_sequencer

Frame-level controller that sits directly upstream of the `error_diffusion` stage and also consumes its results. It buffers a grayscale frame two rows at a time and feeds `error_diffusion` the 5-pixel neighbourhood of each pixel serially. It writes the diffused neighbour values back into its row buffers and streams one halftone bit per pixel in raster order.

## Interface
- `IMG_W`, default 8: frame width in pixels; must be ≥ 2.
- `IMG_H`, default 8: frame height in pixels; must be ≥ 2.
- `DW`, default 8: pixel width.
- `clk`  in  1  — sole clock, rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `start_i`  in  1  — one-cycle pulse; begins a frame. Ignored unless in IDLE.
- `in_valid`  in  1  — input pixel valid.
- `in_data`  in  DW  — input pixel, raster order.
- `in_ready`  out  1  — high only in LOAD. A transfer occurs when `in_valid && in_ready`.
- `ed_valid_o`  out  1  — drives `error_diffusion.valid_i`.
- `ed_data_o`  out  DW  — drives `error_diffusion.data_i`.
- `ed_done_i`  in  1  — from `error_diffusion.done`.
- `ed_res0_i` … `ed_res4_i`  in  DW each — from `result0`…`result4`, in the order center, right, lower-right, lower-center, lower-left.
- `out_valid`  out  1  — one-cycle pulse per processed pixel.
- `out_bit`  out  1  — halftone value; 1 when `ed_res0_i != 0`.
- `frame_done`  out  1  — one-cycle pulse after the last pixel.

## Operation
- Storage:
  - Row buffer `cur[IMG_W]` holds the current row; `nxt[IMG_W]` holds the row below.
  - Counters `x` and `y` track the pixel position; `ld` counts loaded pixels; `k` (0..4) indexes the issue slot.
- IDLE → LOAD on `start_i`, with y=0.
  - LOAD fills `cur` and then `nxt` (2·IMG_W transfers) for the first row.
  - For later rows, LOAD fills only `nxt` (IMG_W transfers).
  - LOAD skips filling `nxt` when y = IMG_H−1.
  - When loading completes, LOAD → ISSUE with x=0.
- ISSUE runs for exactly 5 cycles with `ed_valid_o`=1. `ed_data_o` is, in order:
  - `cur[x]`, `cur[x+1]`, `nxt[x+1]`, `nxt[x]`, `nxt[x-1]`.
  - Any slot that falls outside the frame is driven as 0: x+1 = IMG_W, x−1 < 0, or the last row (all three lower slots).
- ISSUE → WAIT.
- WAIT holds `ed_valid_o`=0 until `ed_done_i`=1. Results are sampled on that same edge, and the state moves to WB.
- WB (1 cycle):
  - `out_valid`=1 and `out_bit` = (`ed_res0_i` != 0).
  - Write `res1`→`cur[x+1]`, `res2`→`nxt[x+1]`, `res3`→`nxt[x]`, `res4`→`nxt[x-1]`.
  - Each write is suppressed when its target is outside the frame.
- WB transitions:
  - If x < IMG_W−1: x+1, go to ISSUE.
  - Else, if y < IMG_H−1: copy `nxt` into `cur` (row swap), y+1, go to LOAD.
  - Else go to DONE.
- DONE: `frame_done`=1 for one cycle, then IDLE.
- Arithmetic: no arithmetic is performed on pixel data, which passes through unchanged. Counters are `$clog2`-sized and never wrap within a frame.

## Timing
- Reset values: every output is 0 (`in_ready`, `ed_valid_o`, `ed_data_o`, `out_valid`, `out_bit`, `frame_done`). State is IDLE, all counters are 0, and buffer contents are don't-care.
- Reset asserted mid-frame in any state forces IDLE and zeroed outputs on the next edge. A subsequent `start_i` begins a clean frame.
- `start_i` arriving outside IDLE is ignored.
- A `start_i` asserted on the same edge as the reset release is ignored.
- LOAD tolerates `in_valid` gaps: it stalls with `in_ready` held high and issues nothing.
- `ed_done_i` arriving in any state other than WAIT is ignored.
- Per-pixel latency:
  - 5 issue cycles, then a wait of D cycles after the last `ed_valid_o` until `ed_done_i`, then 1 WB cycle.
  - `out_valid` fires on the cycle after `ed_done_i` is seen.
- `frame_done` rises one cycle after the final `out_valid`.
- Throughput: no backpressure on the output side; the downstream stage always accepts.

## Test plan
Tests 2–5 use a stub `error_diffusion` that raises `done` 2 cycles after the 5th valid and returns programmable results; parameters are IMG_W=4, IMG_H=2.

1. **Reset:** hold `rst_n`=0 for 2 cycles with `start_i`=1 → all outputs 0, `in_ready`=0, no `ed_valid_o`.
2. **Issue order:** input 0..7; stub returns res0=0 and echoes res1..4 unchanged.
   - Pixel (0,0) issues 0,1,5,4,0.
   - Pixel (0,3) issues 3,0,0,7,6.
   - Row 1, x=1 issues 5,6,0,0,0.
   - 8 `out_valid` pulses, all with `out_bit`=0.
3. **Writeback:** input 0..7; stub returns 255,200,201,202,203.
   - Pixel (0,1) issues 200,2,6,201,202.
   - Every `out_bit`=1.
4. **Stall / frame end:** `in_valid` low for 3 cycles after the 5th pixel → `in_ready` stays high and there is no issue until all 8 pixels are loaded. `frame_done` pulses exactly once, 1 cycle after the 8th `out_valid`.
5. **Reset mid-frame:** assert `rst_n`=0 during WAIT of pixel (0,2) → IDLE on the next edge with all outputs 0. A new `start_i` then reproduces test 2 exactly.
6. **Integration:** connect the real `error_diffusion` with IMG_W=IMG_H=4 and a constant-128 frame → 16 `out_bit` values match the golden model, followed by `frame_done`.
